// File: rtl/dmem_pkg.sv
// Shared types and sizes for the data-memory requester.
package dmem_pkg;
    localparam int AW = 15;
    localparam int DW = 48;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] word_t;
endpackage

// File: rtl/dmem_initiator.sv
// Single-request load/store controller for the 32k x 48 data memory.
// Every output is a register; the comb blocks compute their next values.
module dmem_initiator
    import dmem_pkg::*;
#(
    parameter int AW      = dmem_pkg::AW,
    parameter int DW      = dmem_pkg::DW,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done
);
    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic          write_q, write_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    // Saturating increment: the timer parks at TIMEOUT rather than wrapping.
    assign timer_inc = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            write_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            write_q     <= write_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (mem_done || timer_inc == TMAX) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The strobe is loaded on the accepting edge so it is high for the ISSUE cycle only.
    always_comb begin
        timer_d     = timer_q;
        write_d     = write_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        mem_addr_d  = mem_addr_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    write_d     = req_write;
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata;
                    req_ready_d = 1'b0;
                    mem_read_d  = !req_write;
                    mem_write_d = req_write;
                end
            end
            ISSUE: timer_d = '0;
            WAIT: begin
                if (mem_done) begin
                    rsp_data_d  = write_q ? '0 : mem_rdata;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TMAX) begin
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dmem_initiator.sv
// Bench for dmem_initiator: memory model, transaction-level predictor and directed scenarios.
module tb_dmem_initiator;
    import dmem_pkg::*;
    localparam int TMO = 15;

    logic  clk = 1'b0;
    logic  reset;
    logic  req_valid, req_ready, req_write;
    addr_t req_addr;
    word_t req_wdata;
    logic  rsp_valid, rsp_ready, rsp_err;
    word_t rsp_data;
    addr_t mem_addr;
    logic  mem_read, mem_write, mem_done;
    word_t mem_wdata, mem_rdata;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    dmem_initiator #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Data memory: done one cycle after a strobe; mem_real=0 turns it into a stub that never answers.
    word_t mem [0:(1<<AW)-1];
    logic  mem_real   = 1'b1;
    logic  inj_done   = 1'b0;
    logic  done_q     = 1'b0;
    word_t rdata_q    = '0;
    word_t rdata_junk = '0;
    assign mem_done  = done_q | inj_done;
    assign mem_rdata = rdata_q ^ rdata_junk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        done_q <= mem_real && (mem_read === 1'b1 || mem_write === 1'b1);
        if (mem_write === 1'b1) mem[mem_addr] <= mem_wdata;
        if (mem_read === 1'b1) rdata_q <= mem[mem_addr];
    end

    // Predictor: k counts edges since acceptance; the response is due on the first
    // WAIT edge seeing done, or after TMO WAIT cycles without one.
    bit    m_busy = 0, m_resp = 0, m_write = 0, chk_en = 0;
    int    m_k = 0;
    addr_t m_addr = '0;
    word_t m_wdata = '0, m_data = '0;
    logic  m_err = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_resp = 0; m_addr = '0; m_wdata = '0; m_data = '0; m_err = 1'b0;
            chk_en = 1;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1; m_resp = 0; m_k = 0;
                m_write = req_write; m_addr = req_addr; m_wdata = req_wdata;
            end
        end else if (m_resp) begin
            if (rsp_ready) begin m_busy = 0; m_resp = 0; end
        end else begin
            m_k++;
            if (m_k >= 2) begin
                if (mem_done === 1'b1) begin
                    m_resp = 1; m_err = 1'b0; m_data = m_write ? '0 : mem_rdata;
                end else if (m_k - 1 == TMO) begin
                    m_resp = 1; m_err = 1'b1; m_data = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", req_ready, !m_busy);
            chk("rsp_valid", rsp_valid, m_busy && m_resp);
            chk("mem_read",  mem_read,  m_busy && !m_resp && m_k == 0 && !m_write);
            chk("mem_write", mem_write, m_busy && !m_resp && m_k == 0 && m_write);
            chk("mem_addr",  mem_addr,  m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            if (m_busy && m_resp) begin
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_err",  rsp_err,  m_err);
            end
        end
    end

    // Event log used by the literal checks.
    int    rsp_cnt = 0, rsp_edge = 0;
    logic  rsp_prev = 1'b0;
    word_t rsp_dq[$];
    logic  rsp_eq[$];
    int    strobe_q[$];

    always @(negedge clk) begin
        if (rsp_valid === 1'b1 && !rsp_prev) begin
            rsp_cnt++;
            rsp_edge = cyc;
            rsp_dq.push_back(rsp_data);
            rsp_eq.push_back(rsp_err);
        end
        rsp_prev = (rsp_valid === 1'b1);
        if (mem_read === 1'b1 || mem_write === 1'b1) strobe_q.push_back(cyc);
    end

    task automatic issue(input logic w, input addr_t a, input word_t d, output int acc);
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("issue_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n0, input int budget);
        int n = 0;
        while (rsp_cnt <= n0 && n < budget) begin @(posedge clk); #1; n++; end
        chk("rsp_arrive", rsp_cnt > n0, 1'b1);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, acc2, n0, s0;
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = '1; req_wdata = '1;
        rsp_ready = 1'b0; inj_done = 1'b1; rdata_junk = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data",  rsp_data,  '0);
        chk("rst_rsp_err",   rsp_err,   1'b0);
        chk("rst_mem_read",  mem_read,  1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr",  mem_addr,  '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0; inj_done = 1'b0; rdata_junk = '0; rsp_ready = 1'b1;
        step(2);

        // Store then load back through the memory model.
        n0 = rsp_cnt;
        issue(1'b1, 15'h1234, 48'h123456789ABC, acc);
        wait_rsp(n0, 40);
        chk("st_latency", rsp_edge - acc, 2);
        chk("st_data", rsp_dq[$], '0);
        chk("st_err",  rsp_eq[$], 1'b0);
        n0 = rsp_cnt;
        issue(1'b0, 15'h1234, 48'hDEADBEEF0000, acc);
        wait_rsp(n0, 40);
        chk("ld_latency", rsp_edge - acc, 2);
        chk("ld_data", rsp_dq[$], 48'h123456789ABC);
        chk("ld_err",  rsp_eq[$], 1'b0);

        // Top address, response held by a stalled consumer; req_valid meanwhile must be ignored.
        n0 = rsp_cnt;
        issue(1'b1, 15'h7FFF, 48'hFEDCBA987654, acc);
        wait_rsp(n0, 40);
        rsp_ready = 1'b0;
        n0 = rsp_cnt;
        issue(1'b0, 15'h7FFF, 48'h0, acc);
        wait_rsp(n0, 40);
        s0 = strobe_q.size();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0055; req_wdata = 48'hAAAA;
        step(5);
        chk("hold_valid", rsp_valid, 1'b1);
        chk("hold_ready", req_ready, 1'b0);
        chk("hold_data",  rsp_data,  48'hFEDCBA987654);
        chk("hold_strobes", strobe_q.size() - s0, 0);
        req_valid = 1'b0; rsp_ready = 1'b1;
        step(1);
        chk("hold_release", req_ready, 1'b1);

        // Timeout with a silent stub, then late done pulses in RESP and IDLE.
        mem_real = 1'b0; rsp_ready = 1'b0;
        n0 = rsp_cnt;
        issue(1'b0, 15'h0042, 48'h5555, acc);
        wait_rsp(n0, 40);
        chk("to_latency", rsp_edge - acc, 16);
        chk("to_err",  rsp_eq[$], 1'b1);
        chk("to_data", rsp_dq[$], '0);
        inj_done = 1'b1; step(1); inj_done = 1'b0;
        chk("late_done_err", rsp_err, 1'b1);
        rsp_ready = 1'b1; step(1);
        inj_done = 1'b1; step(1); inj_done = 1'b0;
        step(3);
        chk("late_done_cnt", rsp_cnt - n0, 1);
        chk("late_done_idle", req_ready, 1'b1);

        // Reset while waiting; a done after reset must not produce a response.
        n0 = rsp_cnt;
        issue(1'b0, 15'h0100, 48'h7777, acc);
        step(3);
        reset = 1'b1; step(1); reset = 1'b0;
        inj_done = 1'b1; step(1); inj_done = 1'b0;
        step(5);
        chk("rstw_no_rsp", rsp_cnt - n0, 0);
        chk("rstw_ready",  req_ready, 1'b1);
        chk("rstw_valid",  rsp_valid, 1'b0);

        // Back-to-back loads with the consumer always ready.
        mem_real = 1'b1;
        n0 = rsp_cnt;
        issue(1'b1, 15'h0000, 48'h111122223333, acc);
        wait_rsp(n0, 40);
        n0 = rsp_cnt;
        issue(1'b1, 15'h0001, 48'h444455556666, acc);
        wait_rsp(n0, 40);
        n0 = rsp_cnt;
        s0 = strobe_q.size();
        issue(1'b0, 15'h0000, 48'h0, acc);
        issue(1'b0, 15'h0001, 48'h0, acc2);
        wait_rsp(n0 + 1, 40);
        chk("b2b_accept_gap", acc2 - acc, 4);
        chk("b2b_strobe_cnt", strobe_q.size() - s0, 2);
        if (strobe_q.size() - s0 >= 2)
            chk("b2b_strobe_gap", strobe_q[s0+1] - strobe_q[s0], 4);
        if (rsp_dq.size() >= n0 + 2) begin
            chk("b2b_data0", rsp_dq[n0],   48'h111122223333);
            chk("b2b_data1", rsp_dq[n0+1], 48'h444455556666);
        end
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/dmem_initiator.md
Name: dmem_initiator

Overview:
- Requester-side controller for the 32k x 48-bit data memory.
- Accepts single load/store requests from the CPU over a valid/ready handshake.
- Drives the memory's address, read strobe, write strobe and write data, then waits for the memory's done pulse.
- Returns read data or a write acknowledge to the CPU; a missing done pulse ends in a timeout error response.

Parameters:
- AW, 15, address width in words (32k)
- DW, 48, data word width
- TIMEOUT, 15, number of WAIT cycles without mem_done before an error response

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  AW  word address
- req_wdata  in  DW  store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  CPU consumes the response
- rsp_data  out  DW  load data; 0 for stores and errors
- rsp_err  out  1  request timed out
- mem_addr  out  AW  address to memory
- mem_read  out  1  read strobe to memory
- mem_write  out  1  write strobe to memory
- mem_wdata  out  DW  data to memory
- mem_rdata  in  DW  data from memory
- mem_done  in  1  memory completion, registered one cycle after a strobe

Behaviour:
- All outputs are registered. Reset values: req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. State=IDLE, timer=0.
- IDLE:
  - req_ready=1.
  - When req_valid=1: latch req_write, req_addr and req_wdata into mem_addr/mem_wdata; drop req_ready; go to ISSUE.
- ISSUE:
  - Assert mem_read (load) or mem_write (store) for exactly one cycle; never both.
  - Clear the timer; go to WAIT.
- WAIT:
  - Strobes are 0.
  - mem_done=1: for a load, capture mem_rdata into rsp_data; for a store, set rsp_data=0. Set rsp_err=0; go to RESP.
  - Otherwise increment the timer. When timer reaches TIMEOUT: rsp_err=1, rsp_data=0, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are held stable.
  - On rsp_ready=1: rsp_valid=0, req_ready=1, go to IDLE.
- Latency, with request accepted at edge 0: strobe high during cycle 1; mem_done seen during cycle 2; rsp_valid high from cycle 3. Minimum spacing between accepted requests is 4 cycles with rsp_ready tied high.
- mem_addr and mem_wdata hold their values until the next request is accepted.
- mem_done outside WAIT is ignored, including a late done after a timeout.
- mem_done on the same cycle the timer hits TIMEOUT: done wins, no error.
- req_valid is ignored outside IDLE; no request buffering.
- reset asserted in any state: IDLE on the next edge, strobes low, any pending response dropped; a done arriving after reset is ignored.
- Timer width is $clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- Package dmem_pkg holds:
  - localparams AW=15, DW=48
  - typedef state_t enum {IDLE, ISSUE, WAIT, RESP}
  - typedef addr_t logic[AW-1:0], word_t logic[DW-1:0]
- Single module; no sub-module. The timeout counter is inline.

Test Plan:
- Reset for 2 cycles with junk on all inputs -> req_ready=1, every other output 0.
- Store addr 0x1234, data 0x123456789ABC, then load 0x1234 against the real data memory -> store ack with rsp_data=0, rsp_err=0; load rsp_data=0x123456789ABC, rsp_valid at cycle 3 after accept.
- Load addr 0x7FFF, rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable 5 cycles, req_ready=0, no extra strobes.
- Memory stub never asserts done -> rsp_valid with rsp_err=1, rsp_data=0 after 15 WAIT cycles; a late done is ignored.
- Reset pulsed during WAIT, then stub done -> IDLE, no rsp_valid, req_ready=1.
- Back-to-back loads to 0x0000 and 0x0001 with rsp_ready=1 -> strobes exactly 4 cycles apart, each strobe one cycle wide, correct data per address.
